membank_arb2: RTL and testbench
===============================

# membank_arb2

Two-port round-robin arbiter sharing one latency-1 lane-strobed memory bank (membank256_hf1-style `opreq`/`oprdy`/`ack` protocol) between two requesters (e.g. AES key-schedule and datapath engines). It passes the granted client's command to the bank combinationally. It records the owner of every accepted command in an in-order owner FIFO, so each bank `ack` is routed back to the client that issued that command.

## Interface
Parameters:
- `noLanes`, 32, byte lanes per word
- `laneSize`, 8, bits per lane
- `addrWidth`, 22, word-address width
- `maxOutstanding`, 4, owner-FIFO depth; power of two, ≥2

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `c0_opreq`, `c1_opreq` in 1: client command request.
- `c0_oprdy`, `c1_oprdy` out 1: command accepted this cycle when both `opreq` and `oprdy` are high.
- `c0_rwbar`, `c1_rwbar` in 1: 1 selects read, 0 selects write.
- `c0_wordAddr`, `c1_wordAddr` in `addrWidth`: word address.
- `c0_wdata`, `c1_wdata` in `noLanes*laneSize`: write data.
- `c0_lanes`, `c1_lanes` in `noLanes`: write lane strobes.
- `c0_ack`, `c1_ack` out 1: the bank result for this client's oldest outstanding command is on `rdata`.
- `rdata` out `noLanes*laneSize`: bank read data, broadcast to both clients.
- `mem_opreq`, `mem_rwbar`, `mem_wordAddr`, `mem_wdata`, `mem_lanes` out: command to the bank; widths match the client fields.
- `mem_oprdy` in 1: bank ready.
- `mem_ack` in 1: bank result valid.
- `mem_rdata` in `noLanes*laneSize`: bank read data.
- `err_spurious_ack` out 1: sticky flag.

## Operation
- Round-robin pointer `last` holds the most recently granted client.
- `space` = owner FIFO not full. A pop in the same cycle does **not** free space.
- Grant, computed combinationally:
  - If only one client requests, that client is granted.
  - If both request, the client ≠ `last` is granted.
  - If neither requests, no grant.
- `cN_oprdy` = `mem_oprdy` & `space` & (grant == N). The non-granted client's `oprdy` is 0.
- `mem_opreq` = accept_any. This is the granted client's `opreq` & `mem_oprdy` & `space`.
- `mem_rwbar`/`mem_wordAddr`/`mem_wdata`/`mem_lanes` mux from the granted client. When there is no grant, they mux from client 0 and `mem_opreq`=0.
- On accept:
  - Push the owner ID into the FIFO.
  - Set `last` to the granted client.
- On `mem_ack` with the FIFO non-empty:
  - Pop the head and assert `cHEAD_ack` in the same cycle (combinational from FIFO head).
  - Reads and writes are both acked.
- On `mem_ack` with the FIFO empty:
  - No client ack.
  - Set `err_spurious_ack`, which stays set until reset.
- `rdata` = `mem_rdata`, driven combinationally at all times.
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- Occupancy counter width is log2(`maxOutstanding`)+1. Read and write pointers wrap modulo `maxOutstanding`.
- Reset mid-operation:
  - FIFO is emptied and `last` is set to 1.
  - Acks for pre-reset commands then count as spurious. The bank must be reset together with the arbiter.

## Timing
- Reset values:
  - FIFO empty, `last`=1, so client 0 wins the first tie.
  - `err_spurious_ack`=0.
  - `c0_ack`=`c1_ack`=0, because the FIFO is empty.
  - `oprdy`/`mem_opreq` follow their equations: `mem_opreq`=0 while no client requests.
- Arbiter adds zero cycles of command latency: accept and bank `opreq` occur in the same cycle.
- With a latency-1 bank, `cN_ack` is asserted in the cycle after the accept.
- Sustained throughput is one command per cycle, provided `maxOutstanding` ≥ bank latency + 1.
- Both clients requesting continuously are granted alternately: 0,1,0,1,…
- A client must hold `opreq` and its fields stable until it sees `oprdy` high.
- When the FIFO is full, both `oprdy` outputs are 0 until the cycle after a pop.

## Test plan
- **Reset, single read:**
  - Stimulus: reset 2 cycles, then c0 reads addr 5 with the bank preloaded with 0xA5 pattern.
  - Required: `c0_oprdy`=1 in the request cycle, `mem_wordAddr`=5, `c0_ack`=1 and `rdata`=pattern one cycle later, `c1_ack`=0.
- **Contention:**
  - Stimulus: c0 and c1 both write continuously for 8 cycles to addresses 0..3 and 16..19.
  - Required: grants alternate 0,1,0,…; each client receives 4 acks; read-back returns each client's data with lane strobes honoured.
- **Single-lane write:**
  - Stimulus: c1 writes 0xFF.. with `lanes`=0x1 to addr 9, then reads addr 9.
  - Required: only byte 0 is changed.
- **FIFO full:**
  - Stimulus: a bank model holds `mem_ack` low for 6 cycles while c0 requests continuously.
  - Required: exactly 4 accepts, then `c0_oprdy`=0 until the first ack; acks are returned in order.
- **Spurious ack:**
  - Stimulus: `mem_ack` pulsed with no outstanding command.
  - Required: `err_spurious_ack` becomes 1 and stays 1, no client ack; cleared only by reset.
- **Reset mid-burst:**
  - Stimulus: reset asserted with 2 commands outstanding.
  - Required: the next cycle shows FIFO empty, no acks, and c0 wins the next tie.

Source files
------------

// File: rtl/membank_arb2.sv
// membank_arb2: two-client round-robin arbiter in front of one latency-1 memory bank.
// The granted client's command is passed straight through to the bank, and a small
// owner FIFO remembers who issued each accepted command so every bank ack can be
// steered back to the right client in order.
module membank_arb2 #(
    parameter int noLanes        = 32,
    parameter int laneSize       = 8,
    parameter int addrWidth      = 22,
    parameter int maxOutstanding = 4
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         c0_opreq,
    output logic                         c0_oprdy,
    input  logic                         c0_rwbar,
    input  logic [addrWidth-1:0]         c0_wordAddr,
    input  logic [noLanes*laneSize-1:0]  c0_wdata,
    input  logic [noLanes-1:0]           c0_lanes,
    output logic                         c0_ack,

    input  logic                         c1_opreq,
    output logic                         c1_oprdy,
    input  logic                         c1_rwbar,
    input  logic [addrWidth-1:0]         c1_wordAddr,
    input  logic [noLanes*laneSize-1:0]  c1_wdata,
    input  logic [noLanes-1:0]           c1_lanes,
    output logic                         c1_ack,

    output logic [noLanes*laneSize-1:0]  rdata,

    output logic                         mem_opreq,
    output logic                         mem_rwbar,
    output logic [addrWidth-1:0]         mem_wordAddr,
    output logic [noLanes*laneSize-1:0]  mem_wdata,
    output logic [noLanes-1:0]           mem_lanes,
    input  logic                         mem_oprdy,
    input  logic                         mem_ack,
    input  logic [noLanes*laneSize-1:0]  mem_rdata,

    output logic                         err_spurious_ack
);

    localparam int PW = $clog2(maxOutstanding);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(maxOutstanding);

    // Owner FIFO storage: one bit per slot, 0 = client 0, 1 = client 1.
    logic [maxOutstanding-1:0] r_owner;
    logic [PW-1:0]             r_wrPtr;
    logic [PW-1:0]             r_rdPtr;
    logic [CW-1:0]             r_count;
    logic                      r_last;
    logic                      r_errSpurious;

    logic w_space;
    logic w_empty;
    logic w_grantValid;
    logic w_grantId;
    logic w_accept;
    logic w_pop;
    logic w_headOwner;

    // Occupancy is judged on the registered count only, so a same-cycle pop never frees a slot early.
    assign w_space = (r_count != FULL_COUNT);
    assign w_empty = (r_count == '0);

    // Round-robin grant: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        w_grantValid = c0_opreq | c1_opreq;
        w_grantId    = 1'b0;
        if (c0_opreq && c1_opreq) begin
            w_grantId = ~r_last;
        end else if (c1_opreq) begin
            w_grantId = 1'b1;
        end
    end

    assign w_accept  = w_grantValid & mem_oprdy & w_space;
    assign c0_oprdy  = w_accept & ~w_grantId;
    assign c1_oprdy  = w_accept &  w_grantId;
    assign mem_opreq = w_accept;

    // Command fields follow the granted client; with no grant w_grantId is 0, so client 0 shows through.
    always_comb begin
        mem_rwbar    = c0_rwbar;
        mem_wordAddr = c0_wordAddr;
        mem_wdata    = c0_wdata;
        mem_lanes    = c0_lanes;
        if (w_grantId) begin
            mem_rwbar    = c1_rwbar;
            mem_wordAddr = c1_wordAddr;
            mem_wdata    = c1_wdata;
            mem_lanes    = c1_lanes;
        end
    end

    assign w_pop       = mem_ack & ~w_empty;
    assign w_headOwner = r_owner[r_rdPtr];
    assign c0_ack      = w_pop & ~w_headOwner;
    assign c1_ack      = w_pop &  w_headOwner;
    assign rdata       = mem_rdata;

    assign err_spurious_ack = r_errSpurious;

    // Owner FIFO: push the grantee on accept, pop the head on a bank ack; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_owner[r_wrPtr] <= w_grantId;
                r_wrPtr          <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Remember the last grantee; starting at 1 lets client 0 win the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_grantId;
        end
    end

    // Sticky flag for a bank ack that arrives when nothing is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_errSpurious <= 1'b0;
        end else if (mem_ack && w_empty) begin
            r_errSpurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_membank_arb2.sv
// tb_membank_arb2: randomized and directed bench for membank_arb2 with a latency-1 bank
// model, an independent reference memory and an in-order scoreboard of expected acks.
module tb_membank_arb2;

    localparam int NO_LANES = 32;
    localparam int LANE_SZ  = 8;
    localparam int AW       = 22;
    localparam int MAXO     = 4;
    localparam int DW       = NO_LANES * LANE_SZ;

    typedef struct {
        int             owner;
        bit             isRead;
        logic [DW-1:0]  data;
    } sbEntry_t;

    logic clk;
    logic reset;

    logic [1:0]          opreq;
    logic [1:0]          rwbar;
    logic [AW-1:0]       wordAddr [2];
    logic [DW-1:0]       wdata    [2];
    logic [NO_LANES-1:0] lanes    [2];

    wire c0_oprdy, c1_oprdy, c0_ack, c1_ack;
    wire [DW-1:0] rdata;
    wire mem_opreq, mem_rwbar;
    wire [AW-1:0] mem_wordAddr;
    wire [DW-1:0] mem_wdata;
    wire [NO_LANES-1:0] mem_lanes;
    wire err_spurious_ack;

    logic          mem_oprdy;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    // Bank model state.
    logic [DW-1:0] bankMem [64];
    logic [DW-1:0] bankQ [$];
    bit holdAck    = 0;
    bit forceAck   = 0;
    bit readyRand  = 0;

    // Reference model state.
    logic [DW-1:0] refMem [64];
    sbEntry_t sbQ [$];
    int  grantLog [$];
    int  mCount = 0;
    bit  mLast  = 1;
    bit  mErr   = 0;
    int  acceptCnt [2] = '{0, 0};
    int  ackCnt    [2] = '{0, 0};
    int  randDone  = 0;

    membank_arb2 #(
        .noLanes(NO_LANES), .laneSize(LANE_SZ), .addrWidth(AW), .maxOutstanding(MAXO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .c0_opreq(opreq[0]),
        .c0_oprdy(c0_oprdy),
        .c0_rwbar(rwbar[0]),
        .c0_wordAddr(wordAddr[0]),
        .c0_wdata(wdata[0]),
        .c0_lanes(lanes[0]),
        .c0_ack(c0_ack),
        .c1_opreq(opreq[1]),
        .c1_oprdy(c1_oprdy),
        .c1_rwbar(rwbar[1]),
        .c1_wordAddr(wordAddr[1]),
        .c1_wdata(wdata[1]),
        .c1_lanes(lanes[1]),
        .c1_ack(c1_ack),
        .rdata(rdata),
        .mem_opreq(mem_opreq),
        .mem_rwbar(mem_rwbar),
        .mem_wordAddr(mem_wordAddr),
        .mem_wdata(mem_wdata),
        .mem_lanes(mem_lanes),
        .mem_oprdy(mem_oprdy),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .err_spurious_ack(err_spurious_ack)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] mergeLanes(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] d,
                                                 input logic [NO_LANES-1:0] ln);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NO_LANES; i++)
            if (ln[i]) r[i*LANE_SZ +: LANE_SZ] = d[i*LANE_SZ +: LANE_SZ];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic printSummary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    // Bank: samples mid-cycle, updates its outputs just after the rising edge.
    initial begin
        bit rstS, accS, rwS, ackS;
        logic [AW-1:0] aS;
        logic [DW-1:0] dS;
        logic [NO_LANES-1:0] lS;
        for (int i = 0; i < 64; i++) begin
            bankMem[i] = {NO_LANES{8'hA5}};
            refMem[i]  = {NO_LANES{8'hA5}};
        end
        mem_oprdy = 1;
        mem_ack   = 0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            rstS = reset;
            accS = mem_opreq && mem_oprdy;
            rwS  = mem_rwbar;
            aS   = mem_wordAddr;
            dS   = mem_wdata;
            lS   = mem_lanes;
            ackS = mem_ack;
            @(posedge clk);
            #2;
            if (rstS) begin
                bankQ.delete();
            end else begin
                if (ackS && bankQ.size() > 0) void'(bankQ.pop_front());
                if (accS) begin
                    if (rwS) begin
                        bankQ.push_back(bankMem[aS[5:0]]);
                    end else begin
                        bankMem[aS[5:0]] = mergeLanes(bankMem[aS[5:0]], dS, lS);
                        bankQ.push_back('0);
                    end
                end
            end
            mem_oprdy = readyRand ? ($urandom_range(0, 3) != 0) : 1'b1;
            mem_ack   = (!holdAck && bankQ.size() > 0) || forceAck;
            mem_rdata = (bankQ.size() > 0) ? bankQ[0] : '0;
        end
    end

    // Accept observer: checks grant/ready/mux against the arbitration rules and pushes expected acks.
    initial begin
        bit gValid, gId, space, exp0, exp1, acc0, acc1, popNow;
        int sel, owner;
        sbEntry_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                mCount = 0;
                mLast  = 1;
            end else begin
                gValid = opreq[0] || opreq[1];
                if (opreq[0] && opreq[1]) gId = !mLast;
                else                      gId = opreq[1];
                space = (mCount < MAXO);
                exp0  = mem_oprdy && space && gValid && !gId;
                exp1  = mem_oprdy && space && gValid && gId;
                checkOutput("c0_oprdy", c0_oprdy, exp0);
                checkOutput("c1_oprdy", c1_oprdy, exp1);
                checkOutput("mem_opreq", mem_opreq, exp0 || exp1);
                sel = (gValid && gId) ? 1 : 0;
                checkOutput("mem_wordAddr", mem_wordAddr, wordAddr[sel]);
                checkOutput("mem_rwbar", mem_rwbar, rwbar[sel]);
                checkOutput("mem_wdata", mem_wdata, wdata[sel]);
                checkOutput("mem_lanes", mem_lanes, lanes[sel]);
                acc0 = opreq[0] && c0_oprdy;
                acc1 = opreq[1] && c1_oprdy;
                popNow = mem_ack && (mCount > 0);
                if (acc0 || acc1) begin
                    owner    = acc0 ? 0 : 1;
                    e.owner  = owner;
                    e.isRead = rwbar[owner];
                    if (rwbar[owner]) begin
                        e.data = refMem[wordAddr[owner][5:0]];
                    end else begin
                        e.data = '0;
                        refMem[wordAddr[owner][5:0]] =
                            mergeLanes(refMem[wordAddr[owner][5:0]], wdata[owner], lanes[owner]);
                    end
                    sbQ.push_back(e);
                    grantLog.push_back(owner);
                    acceptCnt[owner]++;
                    mLast  = owner[0];
                    mCount = mCount + 1;
                end
                if (popNow) mCount = mCount - 1;
            end
        end
    end

    // Ack monitor: pops the oldest expected response whenever the bank acks.
    initial begin
        sbEntry_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                sbQ.delete();
                mErr = 0;
            end else begin
                checkOutput("err_spurious_ack", err_spurious_ack, mErr);
                if (mem_ack && sbQ.size() > 0) begin
                    e = sbQ.pop_front();
                    checkOutput("c0_ack", c0_ack, e.owner == 0);
                    checkOutput("c1_ack", c1_ack, e.owner == 1);
                    if (e.isRead) checkOutput("rdata", rdata, e.data);
                    ackCnt[e.owner]++;
                end else begin
                    checkOutput("c0_ack_idle", c0_ack, 1'b0);
                    checkOutput("c1_ack_idle", c1_ack, 1'b0);
                    if (mem_ack) mErr = 1;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        errors++;
        checks++;
        printSummary();
        $finish;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input int n);
        reset = 1;
        idle(n);
        reset = 0;
    endtask

    // Drives one command on a client and holds it until the arbiter accepts it.
    task automatic applyStimulus(input int cl, input bit rd, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [NO_LANES-1:0] ln,
                                 output int waited);
        bit accepted;
        rwbar[cl]    = rd;
        wordAddr[cl] = a;
        wdata[cl]    = d;
        lanes[cl]    = ln;
        opreq[cl]    = 1;
        waited   = 0;
        accepted = 0;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            waited++;
            accepted = (cl == 1) ? c1_oprdy : c0_oprdy;
        end
        if (!accepted) begin
            errors++;
            checks++;
            $display("[TB] FAIL accept_timeout: client %0d never saw oprdy", cl);
        end
        @(posedge clk);
        #1;
        opreq[cl] = 0;
    endtask

    task automatic randomClient(input int cl, input int n);
        int w;
        logic [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            idle($urandom_range(0, 2));
            d = {8{$urandom}};
            applyStimulus(cl, $urandom_range(0, 1), AW'($urandom_range(0, 31)), d,
                          NO_LANES'($urandom), w);
        end
        randDone++;
    endtask

    initial begin
        int w, snap0, snap1;
        logic [DW-1:0] pattern, oneLane, ones;
        opreq = '0;
        rwbar = '0;
        for (int i = 0; i < 2; i++) begin
            wordAddr[i] = '0;
            wdata[i]    = '0;
            lanes[i]    = '0;
        end
        pattern = {NO_LANES{8'hA5}};
        ones    = {NO_LANES{8'hFF}};
        oneLane = {{(NO_LANES-1){8'hA5}}, 8'hFF};

        // Reset state and a single read.
        doReset(2);
        @(negedge clk);
        checkOutput("reset_c0_ack", c0_ack, 1'b0);
        checkOutput("reset_c1_ack", c1_ack, 1'b0);
        checkOutput("reset_err", err_spurious_ack, 1'b0);
        checkOutput("reset_mem_opreq", mem_opreq, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(0, 1, 5, '0, '0, w);
        checkOutput("t1_accept_wait", w, 1);
        @(negedge clk);
        checkOutput("t1_c0_ack", c0_ack, 1'b1);
        checkOutput("t1_c1_ack", c1_ack, 1'b0);
        checkOutput("t1_rdata", rdata, pattern);
        @(posedge clk);
        #1;

        // Contention: both clients write continuously from a fresh reset.
        doReset(2);
        grantLog.delete();
        snap0 = ackCnt[0];
        snap1 = ackCnt[1];
        fork
            begin
                int ww;
                for (int i = 0; i < 4; i++)
                    applyStimulus(0, 0, AW'(i), {8{$urandom}}, NO_LANES'($urandom), ww);
            end
            begin
                int ww;
                for (int i = 0; i < 4; i++)
                    applyStimulus(1, 0, AW'(16 + i), {8{$urandom}}, NO_LANES'($urandom), ww);
            end
        join
        idle(3);
        checkOutput("t2_grant_count", grantLog.size(), 8);
        for (int i = 0; i < 8 && i < grantLog.size(); i++)
            checkOutput("t2_grant_order", grantLog[i], i % 2);
        checkOutput("t2_c0_acks", ackCnt[0] - snap0, 4);
        checkOutput("t2_c1_acks", ackCnt[1] - snap1, 4);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, AW'(i), '0, '0, w);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, AW'(16 + i), '0, '0, w);
        idle(3);

        // Single-lane write then read-back.
        applyStimulus(1, 0, 9, ones, 32'h1, w);
        applyStimulus(1, 1, 9, '0, '0, w);
        @(negedge clk);
        checkOutput("t3_c1_ack", c1_ack, 1'b1);
        checkOutput("t3_rdata", rdata, oneLane);
        @(posedge clk);
        #1;
        idle(2);

        // FIFO full: bank withholds acks while client 0 keeps requesting.
        holdAck = 1;
        snap0 = acceptCnt[0];
        fork
            begin
                int ww;
                for (int i = 0; i < 6; i++) applyStimulus(0, 1, AW'(i), '0, '0, ww);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (k >= 4) checkOutput("t4_full_oprdy", c0_oprdy, 1'b0);
                end
                checkOutput("t4_accepts", acceptCnt[0] - snap0, 4);
                @(posedge clk);
                #1;
                holdAck = 0;
            end
        join
        idle(4);

        // Spurious ack with nothing outstanding.
        forceAck = 1;
        @(negedge clk);
        checkOutput("t5_c0_ack", c0_ack, 1'b0);
        checkOutput("t5_c1_ack", c1_ack, 1'b0);
        @(posedge clk);
        #1;
        forceAck = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t5_err_sticky", err_spurious_ack, 1'b1);
        end
        @(posedge clk);
        #1;
        doReset(1);
        @(negedge clk);
        checkOutput("t5_err_cleared", err_spurious_ack, 1'b0);
        @(posedge clk);
        #1;

        // Reset with two commands outstanding.
        holdAck = 1;
        applyStimulus(0, 1, 1, '0, '0, w);
        applyStimulus(1, 1, 2, '0, '0, w);
        reset = 1;
        idle(1);
        reset   = 0;
        holdAck = 0;
        fork
            begin
                int ww;
                applyStimulus(0, 0, 40, {8{$urandom}}, NO_LANES'($urandom), ww);
            end
            begin
                int ww;
                applyStimulus(1, 0, 41, {8{$urandom}}, NO_LANES'($urandom), ww);
            end
            begin
                @(negedge clk);
                checkOutput("t6_c0_wins", c0_oprdy, 1'b1);
                checkOutput("t6_c1_waits", c1_oprdy, 1'b0);
                checkOutput("t6_no_c0_ack", c0_ack, 1'b0);
                checkOutput("t6_no_c1_ack", c1_ack, 1'b0);
            end
        join
        idle(4);

        // Randomized traffic with random bank stalls and ack holds.
        readyRand = 1;
        randDone  = 0;
        fork
            randomClient(0, 120);
            randomClient(1, 120);
            begin
                while (randDone < 2) begin
                    @(posedge clk);
                    #1;
                    holdAck = ($urandom_range(0, 9) == 0);
                end
                holdAck = 0;
            end
        join
        readyRand = 0;
        idle(12);
        checkOutput("drain_scoreboard", sbQ.size(), 0);
        checkOutput("drain_acks", ackCnt[0] + ackCnt[1], acceptCnt[0] + acceptCnt[1] - 2);

        printSummary();
        $finish;
    end

endmodule
